// File: rtl/rob.sv
// Reorder buffer: circular FIFO of in-flight instructions in program order.
// Dispatch appends up to N entries at the tail; retire consumes up to N from the head.

package rob_pkg;
  typedef struct packed {
    logic [31:0] npc;
    logic [5:0]  t_new;
    logic [5:0]  t_old;
    logic [4:0]  dest;
  } ROB_PACKET;
endpackage

// Per-lane slice: write address/enable for dispatch lane, read mux for retire window lane.
module rob_lane
  import rob_pkg::*;
#(
  parameter int LANE   = 0,
  parameter int ROB_SZ = 32,
  parameter int IDX_W  = 5,
  parameter int CNT_W  = 2
) (
  input  logic [IDX_W-1:0]       head_idx_i,
  input  logic [IDX_W-1:0]       tail_idx_i,
  input  logic [CNT_W-1:0]       wr_cnt_i,
  input  logic [CNT_W-1:0]       rd_cnt_i,
  input  ROB_PACKET [ROB_SZ-1:0] entries_i,
  output logic                   wr_en_o,
  output logic [IDX_W-1:0]       wr_idx_o,
  output ROB_PACKET              out_o
);
  logic [IDX_W-1:0] rd_idx;

  // Index arithmetic wraps naturally since ROB_SZ == 2**IDX_W.
  assign wr_idx_o = tail_idx_i + IDX_W'(LANE);
  assign wr_en_o  = CNT_W'(LANE) < wr_cnt_i;
  assign rd_idx   = head_idx_i + IDX_W'(LANE);
  assign out_o    = (CNT_W'(LANE) < rd_cnt_i) ? entries_i[rd_idx] : '0;
endmodule

module rob
  import rob_pkg::*;
#(
  parameter int N               = 3,
  parameter int ROB_SZ          = 32,
  parameter int ROB_IDX_BITS    = $clog2(ROB_SZ),
  parameter int NUM_SCALAR_BITS = $clog2(N+1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  ROB_PACKET [N-1:0]          rob_inputs,
  input  logic [NUM_SCALAR_BITS-1:0] rob_inputs_valid,
  output logic [NUM_SCALAR_BITS-1:0] rob_spots,
  output logic [ROB_IDX_BITS:0]      rob_tail,
  input  logic                       tail_restore_valid,
  input  logic [ROB_IDX_BITS:0]      tail_restore,
  output ROB_PACKET [N-1:0]          rob_outputs,
  output logic [NUM_SCALAR_BITS-1:0] rob_outputs_valid,
  input  logic [NUM_SCALAR_BITS-1:0] num_retiring
);
  localparam int PW = ROB_IDX_BITS + 1;

  logic [PW-1:0]              head_q, head_d, tail_q, tail_d;
  ROB_PACKET [ROB_SZ-1:0]     entries_q;
  logic [PW-1:0]              count, free;
  logic [NUM_SCALAR_BITS-1:0] spots, outs_vld, ret_cnt, wr_cnt;
  logic [N-1:0]                   wr_en;
  logic [N-1:0][ROB_IDX_BITS-1:0] wr_idx;

  // Pointers carry a wrap bit, so count spans 0..ROB_SZ without ambiguity.
  assign count    = tail_q - head_q;
  assign free     = PW'(ROB_SZ) - count;
  assign spots    = (free > PW'(N))  ? NUM_SCALAR_BITS'(N) : free[NUM_SCALAR_BITS-1:0];
  assign outs_vld = (count > PW'(N)) ? NUM_SCALAR_BITS'(N) : count[NUM_SCALAR_BITS-1:0];

  // Over-requests are clamped so a live entry is never overwritten or over-retired.
  assign ret_cnt = (num_retiring > outs_vld) ? outs_vld : num_retiring;
  assign wr_cnt  = tail_restore_valid ? '0 :
                   (rob_inputs_valid > spots) ? spots : rob_inputs_valid;

  assign head_d = head_q + PW'(ret_cnt);
  assign tail_d = tail_restore_valid ? tail_restore : tail_q + PW'(wr_cnt);

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Entry storage has no reset; liveness is defined purely by head/tail.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        if (wr_en[i]) entries_q[wr_idx[i]] <= rob_inputs[i];
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    rob_lane #(
      .LANE(g), .ROB_SZ(ROB_SZ), .IDX_W(ROB_IDX_BITS), .CNT_W(NUM_SCALAR_BITS)
    ) u_lane (
      .head_idx_i (head_q[ROB_IDX_BITS-1:0]),
      .tail_idx_i (tail_q[ROB_IDX_BITS-1:0]),
      .wr_cnt_i   (wr_cnt),
      .rd_cnt_i   (outs_vld),
      .entries_i  (entries_q),
      .wr_en_o    (wr_en[g]),
      .wr_idx_o   (wr_idx[g]),
      .out_o      (rob_outputs[g])
    );
  end

  assign rob_spots         = spots;
  assign rob_outputs_valid = outs_vld;
  assign rob_tail          = tail_q;
endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for rob: a queue of live entries in program order predicts
// the retire window, free spots and tail pointer after every clock.
module tb_rob;
  import rob_pkg::*;

  localparam int N  = 3;
  localparam int SZ = 32;

  logic             clock = 1'b0;
  logic             reset;
  ROB_PACKET [N-1:0] rob_inputs;
  logic [1:0]       rob_inputs_valid;
  logic [1:0]       rob_spots;
  logic [5:0]       rob_tail;
  logic             tail_restore_valid;
  logic [5:0]       tail_restore;
  ROB_PACKET [N-1:0] rob_outputs;
  logic [1:0]       rob_outputs_valid;
  logic [1:0]       num_retiring;

  rob #(.N(N), .ROB_SZ(SZ)) dut (
    .clock              (clock),
    .reset              (reset),
    .rob_inputs         (rob_inputs),
    .rob_inputs_valid   (rob_inputs_valid),
    .rob_spots          (rob_spots),
    .rob_tail           (rob_tail),
    .tail_restore_valid (tail_restore_valid),
    .tail_restore       (tail_restore),
    .rob_outputs        (rob_outputs),
    .rob_outputs_valid  (rob_outputs_valid),
    .num_retiring       (num_retiring)
  );

  always #5 clock = ~clock;

  ROB_PACKET exp_q[$];
  logic [5:0] m_head, m_tail;
  int seq = 1;
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ROB_PACKET mk(input int s);
    ROB_PACKET p;
    p.npc   = 32'(s * 4);
    p.t_new = 6'(s + 32);
    p.t_old = 6'(s);
    p.dest  = 5'(s);
    return p;
  endfunction

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check_all();
    int vld;
    vld = mn(exp_q.size(), N);
    chk("valid", 64'(rob_outputs_valid), 64'(vld));
    chk("spots", 64'(rob_spots), 64'(mn(SZ - exp_q.size(), N)));
    chk("tail",  64'(rob_tail),  64'(m_tail));
    for (int i = 0; i < N; i++)
      chk($sformatf("lane%0d", i), 64'(rob_outputs[i]), (i < vld) ? 64'(exp_q[i]) : 64'(0));
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cyc(input int nin, input int nret, input bit rv, input logic [5:0] rt, input bit rst);
    int vld, spots, wr, ret, nsz;
    vld   = mn(exp_q.size(), N);
    spots = mn(SZ - exp_q.size(), N);
    for (int i = 0; i < N; i++) rob_inputs[i] = mk(seq + i);
    rob_inputs_valid   = 2'(nin);
    num_retiring       = 2'(nret);
    tail_restore_valid = rv;
    tail_restore       = rt;
    reset              = ~rst;
    if (rst) begin
      exp_q.delete();
      m_head = '0;
      m_tail = '0;
    end else begin
      ret = mn(nret, vld);
      for (int i = 0; i < ret; i++) void'(exp_q.pop_front());
      m_head = m_head + 6'(ret);
      if (rv) begin
        m_tail = rt;
        nsz = int'(6'(rt - m_head));
        while (exp_q.size() > nsz) void'(exp_q.pop_back());
      end else begin
        wr = mn(nin, spots);
        for (int i = 0; i < wr; i++) exp_q.push_back(mk(seq + i));
        m_tail = m_tail + 6'(wr);
        seq += wr;
      end
    end
    @(posedge clock);
    #1;
    check_all();
  endtask

  initial begin
    logic [5:0] ckpt;
    int guard, nin, nret, k;
    bit rv;
    reset = 1'b0;
    rob_inputs = '0;
    rob_inputs_valid = '0;
    num_retiring = '0;
    tail_restore_valid = 1'b0;
    tail_restore = '0;
    m_head = '0;
    m_tail = '0;

    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 2, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Basic dispatch then partial retire.
    cyc(3, 0, 0, 0, 0);
    chk("t_new1", 64'(rob_outputs[1].t_new), 64'(34));
    cyc(0, 2, 0, 0, 0);
    chk("t_new0", 64'(rob_outputs[0].t_new), 64'(35));
    chk("tail3", 64'(rob_tail), 64'(3));

    // Fill to capacity, then illegal dispatch alongside retire.
    guard = 0;
    while (exp_q.size() < SZ && guard < 40) begin
      cyc(mn(3, SZ - exp_q.size()), 0, 0, 0, 0);
      guard++;
    end
    chk("full_spots", 64'(rob_spots), 64'(0));
    cyc(2, 2, 0, 0, 0);
    chk("after_full_spots", 64'(rob_spots), 64'(2));

    // Drain, walk both pointers to 30, dispatch across the wrap.
    guard = 0;
    while (exp_q.size() > 0 && guard < 40) begin cyc(0, 3, 0, 0, 0); guard++; end
    guard = 0;
    while (m_tail[4:0] != 5'd30 && guard < 70) begin cyc(1, 1, 0, 0, 0); guard++; end
    cyc(0, 1, 0, 0, 0);
    cyc(3, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Checkpoint at tail=5 with head=0, then restore with dispatch and retire.
    guard = 0;
    while (m_tail[4:0] != 5'd0 && guard < 70) begin cyc(1, 1, 0, 0, 0); guard++; end
    guard = 0;
    while (exp_q.size() > 0 && guard < 40) begin cyc(0, 3, 0, 0, 0); guard++; end
    cyc(3, 0, 0, 0, 0);
    cyc(2, 0, 0, 0, 0);
    ckpt = m_tail;
    chk("ckpt_idx", 64'(rob_tail[4:0]), 64'(5));
    cyc(3, 0, 0, 0, 0);
    cyc(3, 0, 0, 0, 0);
    cyc(3, 1, 1, ckpt, 0);
    chk("restore_cnt", 64'(rob_outputs_valid), 64'(3));

    // Mid-stream reset wins over dispatch and restore.
    guard = 0;
    while (exp_q.size() < 17 && guard < 20) begin cyc(mn(3, 17 - exp_q.size()), 0, 0, 0, 0); guard++; end
    cyc(3, 0, 1, m_tail, 1);
    chk("rst_tail", 64'(rob_tail), 64'(0));

    // Random legal-ish traffic, including clamped over-requests and restores.
    for (int c = 0; c < 200; c++) begin
      nin  = $urandom_range(0, 3);
      nret = $urandom_range(0, 3);
      rv   = ($urandom_range(0, 9) == 0);
      k    = mn(nret, mn(exp_q.size(), N));
      if (rv) begin
        ckpt = m_head + 6'(k) + 6'($urandom_range(0, exp_q.size() - k));
        cyc(nin, nret, 1, ckpt, 0);
      end else begin
        cyc(nin, nret, 0, 0, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/rob.md
Name: rob

Overview:
- Reorder buffer: a circular FIFO of ROB_PACKET entries that holds in-flight instructions in program order.
- Dispatch writes up to N entries per cycle at the tail.
- The oldest up to N entries are presented to the retire stage; the retire stage returns how many it consumed, and the head advances by that amount.
- Also supplies tail checkpoints to branch logic and accepts a tail restore on mispredict.

Parameters:
- N, 3: superscalar width (dispatch and retire lanes).
- ROB_SZ, 32: entry count; must be a power of two, ROB_SZ >= N.
- ROB_IDX_BITS, $clog2(ROB_SZ): entry index width.
- NUM_SCALAR_BITS, $clog2(N+1): width of per-cycle counts.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-low reset; state clears on a posedge where reset==0.
- rob_inputs  in  N x ROB_PACKET  dispatched entries; lane 0 is oldest.
- rob_inputs_valid  in  NUM_SCALAR_BITS  number of valid lanes in rob_inputs, 0..N.
- rob_spots  out  NUM_SCALAR_BITS  free entries, clamped: min(ROB_SZ - count, N).
- rob_tail  out  ROB_IDX_BITS+1  current tail pointer including wrap bit; dispatch checkpoints this value.
- tail_restore_valid  in  1  mispredict recovery request.
- tail_restore  in  ROB_IDX_BITS+1  checkpointed tail pointer to restore.
- rob_outputs  out  N x ROB_PACKET  head-relative entries; lane i = entry[(head+i) mod ROB_SZ].
- rob_outputs_valid  out  NUM_SCALAR_BITS  min(count, N).
- num_retiring  in  NUM_SCALAR_BITS  entries consumed this cycle, 0..rob_outputs_valid.

Behaviour:
- State: entries[ROB_SZ], head and tail, each ROB_IDX_BITS+1 wide; the MSB is the wrap bit.
- count = tail - head, modulo 2^(ROB_IDX_BITS+1), range 0..ROB_SZ.
- Empty: count==0. Full: count==ROB_SZ (equal index bits, differing wrap bits).
- Reset (reset==0 at posedge): head=0, tail=0, entry contents unchanged.
  - Following cycle: rob_outputs_valid=0, rob_spots=N, rob_tail=0, rob_outputs all '0.
- Outputs are combinational from registered state only; no combinational path from any input to any output.
  - rob_outputs lanes with i >= rob_outputs_valid are driven '0.
- Dispatch:
  - Lane i (i < rob_inputs_valid) is written to entries[(tail+i) mod ROB_SZ].
  - tail_next = tail + rob_inputs_valid.
  - Written entries are visible on rob_outputs one cycle later at the earliest.
- Dispatch overflow: rob_inputs_valid > rob_spots is a protocol error (bench asserts it). The ROB writes only rob_spots lanes and never overwrites a live entry.
- Retire: head_next = head + num_retiring.
  - num_retiring > rob_outputs_valid is a protocol error; the ROB clamps the advance to rob_outputs_valid.
- Simultaneous dispatch and retire: both apply in the same cycle.
  - When full with retire 2 and dispatch 2, count stays ROB_SZ.
  - rob_spots is computed from the pre-retire count; freed entries are reusable the next cycle, not the same cycle.
- Wrap-around: index bits wrap modulo ROB_SZ and the wrap bit toggles.
  - A dispatch group or output window may straddle entry ROB_SZ-1 to entry 0.
- Mispredict restore (tail_restore_valid=1):
  - tail_next = tail_restore, and dispatch in that cycle is ignored.
  - Retire in the same cycle still advances head.
  - Entries between tail_restore and the old tail are discarded logically; they are not cleared.
  - Legal only when tail_restore lies in [head_next, tail] in wrap-aware order, so count never goes negative.
- Restore takes priority over dispatch.
- Reset takes priority over restore, dispatch and retire.
- Reset asserted mid-operation discards all entries regardless of the other inputs in that cycle.

Test Plan:
- Reset held 0 for 2 cycles, then released -> rob_outputs_valid=0, rob_spots=3, rob_tail=0; with N=3 and ROB_SZ=32, num_retiring=0 and no dispatch hold that state indefinitely.
- Dispatch 3 entries with T_new=33,34,35 (NPC 0x4,0x8,0xC) -> next cycle rob_outputs_valid=3, lanes in order with T_new=33,34,35; num_retiring=2 -> next cycle valid=1, lane0 T_new=35, rob_tail=3.
- Fill to 32 entries -> rob_spots=0 with valid=3. Then retire 2 while dispatching 2 (illegal, spots=0) -> no entry overwritten, count=30, spots=2 next cycle.
- Advance head to 30, dispatch 3 -> entries land at indices 30,31,0 and tail wrap bit toggles; rob_outputs lanes show those 3 entries in order across the wrap.
- rob_tail=5 checkpointed, then dispatch to tail=11; assert tail_restore=5 with dispatch 3 and retire 1 in the same cycle -> tail=5, head advances 1, dispatched entries dropped, count=4.
- Mid-stream with count=17, drive reset=0 concurrently with dispatch 3 and restore -> next cycle count=0, valid=0, spots=3, tail=0.
